// File: rtl/abr_prim_subreg_array.sv
// abr_prim_subreg_array: array of SW/HW shared register fields with masks, lock, priority and strobes
package abr_prim_subreg_pkg;
  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;
endpackage

module abr_prim_subreg_array
  import abr_prim_subreg_pkg::*;
#(
  parameter int unsigned NumFields = 4,
  parameter int unsigned DW = 8,
  parameter sw_access_e SwAccess [NumFields] = '{default: SwAccessRW},
  parameter logic [NumFields*DW-1:0] ResetVal = '0,
  parameter bit HwPrio = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [NumFields*DW-1:0] wd_i,
  input  logic [NumFields*DW-1:0] wmask_i,
  input  logic                    lock_i,
  input  logic [NumFields-1:0]    de_i,
  input  logic [NumFields*DW-1:0] d_i,
  output logic [NumFields*DW-1:0] q_o,
  output logic [NumFields*DW-1:0] qs_o,
  output logic [NumFields-1:0]    qe_o,
  output logic                    wr_err_o
);
  logic swwe;
  logic [NumFields*DW-1:0] q, qNext;
  logic [NumFields-1:0] qeNext, errField;
  assign swwe = we_i & ~lock_i;
  for (genvar f = 0; f < NumFields; f++) begin : gField
    localparam sw_access_e Mode = SwAccess[f];
    localparam bit Writable = (Mode != SwAccessRO) && (Mode != SwAccessRC);
    logic [DW-1:0] m, w, base, sw, nxt;
    logic anyM;
    if (Mode > SwAccessRC) begin : gBadMode
      $fatal(1, "abr_prim_subreg_array: illegal SwAccess value");
    end
    assign m = wmask_i[f*DW +: DW];
    assign w = wd_i[f*DW +: DW];
    assign anyM = |m;
    assign base = de_i[f] ? d_i[f*DW +: DW] : q[f*DW +: DW];
    // Next field value: HW base, then SW op or read-clear, with optional HW override
    always_comb begin
      sw = (Mode == SwAccessRW || Mode == SwAccessWO) ? ((w & m) | (base & ~m)) :
           (Mode == SwAccessW1S) ? (base | (w & m)) :
           (Mode == SwAccessW1C) ? (base & ~(w & m)) :
           (Mode == SwAccessW0C) ? (base & ~(~w & m)) : base;
      nxt = (HwPrio && de_i[f]) ? d_i[f*DW +: DW] :
            (Mode == SwAccessRC && re_i) ? '0 :
            swwe ? sw : base;
    end
    assign qNext[f*DW +: DW] = nxt;
    assign qeNext[f] = swwe & anyM & Writable;
    assign errField[f] = we_i & anyM & (lock_i | ~Writable);
    assign qs_o[f*DW +: DW] = (Mode == SwAccessWO) ? '0 : q[f*DW +: DW];
  end
  // Register state, write strobes and error pulse; reset drops any pending write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= ResetVal;
      qe_o <= '0;
      wr_err_o <= 1'b0;
    end else begin
      q <= qNext;
      qe_o <= qeNext;
      wr_err_o <= |errField;
    end
  end
  assign q_o = q;
endmodule

// File: tb/tb_abr_prim_subreg_array.sv
// tb_abr_prim_subreg_array: directed scoreboard bench for SW-wins and HW-wins instances
module tb_abr_prim_subreg_array;
  import abr_prim_subreg_pkg::*;
  localparam sw_access_e Modes [4] = '{SwAccessRW, SwAccessW1C, SwAccessRC, SwAccessWO};
  localparam logic [31:0] Rv = 32'h4433_2211;

  logic clk = 0, rst = 1, we = 0, re = 0, lock = 0;
  logic [31:0] wd = 0, wm = 0, d = 0;
  logic [3:0] de = 0;
  logic [31:0] q0, qs0, q1, qs1;
  logic [3:0] qe0, qe1;
  logic err0, err1;

  typedef struct {
    string tag;
    int sig;
    int dut;
    logic [31:0] expv;
  } entry_t;
  entry_t sb[$];
  int compared = 0, mismatched = 0;

  abr_prim_subreg_array #(.NumFields(4), .DW(8), .SwAccess(Modes), .ResetVal(Rv), .HwPrio(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .wd_i(wd), .wmask_i(wm), .lock_i(lock),
    .de_i(de), .d_i(d), .q_o(q0), .qs_o(qs0), .qe_o(qe0), .wr_err_o(err0));
  abr_prim_subreg_array #(.NumFields(4), .DW(8), .SwAccess(Modes), .ResetVal(Rv), .HwPrio(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .wd_i(wd), .wmask_i(wm), .lock_i(lock),
    .de_i(de), .d_i(d), .q_o(q1), .qs_o(qs1), .qe_o(qe1), .wr_err_o(err1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] obs(int dut, int sig);
    case (sig)
      0: return dut == 0 ? q0 : q1;
      1: return dut == 0 ? qs0 : qs1;
      2: return dut == 0 ? {28'b0, qe0} : {28'b0, qe1};
      default: return dut == 0 ? {31'b0, err0} : {31'b0, err1};
    endcase
  endfunction

  task automatic push(string tag, int sig, logic [31:0] e0, logic [31:0] e1);
    sb.push_back('{tag, sig, 0, e0});
    sb.push_back('{tag, sig, 1, e1});
  endtask

  task automatic expq(string tag, logic [31:0] e0, logic [31:0] e1);
    push({tag, "_q"}, 0, e0, e1);
  endtask

  task automatic expstb(string tag, logic [3:0] qe, logic er);
    push({tag, "_qe"}, 2, {28'b0, qe}, {28'b0, qe});
    push({tag, "_err"}, 3, {31'b0, er}, {31'b0, er});
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      entry_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs(e.dut, e.sig);
      compared++;
      assert (o === e.expv) else begin
        mismatched++;
        $error("FAIL %s dut%0d observed %h expected %h", e.tag, e.dut, o, e.expv);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    we = 0; re = 0; lock = 0; wd = 0; wm = 0; de = 0; d = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    expq("reset", Rv, Rv); expstb("reset", 4'b0, 1'b0);
    push("reset_qs", 1, 32'h0033_2211, 32'h0033_2211);
    tick();
    rst = 0;
    expq("hold", Rv, Rv); tick();
    we = 1; wd = 32'h0000_00F0; wm = 32'h0000_003C;
    expq("rw_mask", 32'h4433_2231, 32'h4433_2231); expstb("rw_mask", 4'b0001, 1'b0); tick();
    idle();
    expstb("rw_pulse_end", 4'b0, 1'b0); tick();
    de = 4'b0110; d = 32'h005A_FF00;
    expq("hw_load", 32'h445A_FF31, 32'h445A_FF31); expstb("hw_load", 4'b0, 1'b0); tick();
    idle(); we = 1; wd = 32'h0000_0F00; wm = 32'h0000_FF00;
    expq("w1c", 32'h445A_F031, 32'h445A_F031); expstb("w1c", 4'b0010, 1'b0); tick();
    de = 4'b0010; d = 32'h0000_AA00;
    expq("w1c_prio", 32'h445A_A031, 32'h445A_AA31); expstb("w1c_prio", 4'b0010, 1'b0); tick();
    idle(); re = 1;
    push("rc_qs_preclear", 1, 32'h005A_A031, 32'h005A_AA31); drain();
    expq("rc_clear", 32'h4400_A031, 32'h4400_AA31); expstb("rc_clear", 4'b0, 1'b0); tick();
    idle(); de = 4'b0100; d = 32'h0033_0000;
    expq("rc_reload", 32'h4433_A031, 32'h4433_AA31); tick();
    idle(); we = 1; wd = 32'h00FF_0000; wm = 32'h00FF_0000;
    expq("rc_write", 32'h4433_A031, 32'h4433_AA31); expstb("rc_write", 4'b0, 1'b1); tick();
    idle();
    expstb("err_pulse_end", 4'b0, 1'b0); tick();
    we = 1; lock = 1; wd = '1; wm = '1;
    expq("locked", 32'h4433_A031, 32'h4433_AA31); expstb("locked", 4'b0, 1'b1); tick();
    idle();
    expstb("locked_end", 4'b0, 1'b0); tick();
    we = 1; wd = '1; wm = '1;
    expq("unlocked", 32'hFF33_00FF, 32'hFF33_00FF); expstb("unlocked", 4'b1011, 1'b1); tick();
    idle(); we = 1; wd = 32'h5500_0000; wm = 32'hFF00_0000;
    expq("wo_b2b1", 32'h5533_00FF, 32'h5533_00FF); expstb("wo_b2b1", 4'b1000, 1'b0); tick();
    wd = 32'h7700_0000;
    expq("wo_b2b2", 32'h7733_00FF, 32'h7733_00FF); expstb("wo_b2b2", 4'b1000, 1'b0);
    push("wo_qs", 1, 32'h0033_00FF, 32'h0033_00FF); tick();
    idle(); we = 1; wd = '1; wm = 32'h0000_0000;
    expq("zero_mask", 32'h7733_00FF, 32'h7733_00FF); expstb("zero_mask", 4'b0, 1'b0); tick();
    idle(); rst = 1; we = 1; wd = '1; wm = '1;
    expq("rst_write", Rv, Rv); expstb("rst_write", 4'b0, 1'b0); tick();
    idle(); rst = 0;
    expq("post_rst", Rv, Rv); expstb("post_rst", 4'b0, 1'b0); tick();
    re = 1; de = 4'b0100; d = 32'h0099_0000;
    expq("rc_vs_hw", 32'h4400_2211, 32'h4499_2211); tick();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
